ecc_sram_rmw_bank: RTL and testbench

Parametrised SECDED-protected TCDM bank that replaces per-width ECC wrappers in the cluster L1. Every stored word carries Hsiao SECDED check bits. Sub-word stores are handled by an internal read-modify-write sequence, and correctable read errors are optionally scrubbed back to memory. A saturating corrected-error counter is exposed for the cluster peripheral block.

---
 rtl/ecc_sram_pkg.sv | 45 ++++
 rtl/ecc_sram_codec.sv | 67 ++++++
 rtl/ecc_sram_rmw_bank.sv | 167 ++++++++++++++++
 tb/tb_ecc_sram_rmw_bank.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_sram_pkg.sv
// Shared types and helpers for the SECDED-protected SRAM bank.
package ecc_sram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMW   = 2'd1,
        SCRUB = 2'd2
    } state_e;

    // Check-bit count for a given payload width; 0 flags an unsupported width.
    function automatic int ecc_width(input int data_width);
        if (data_width == 32) return 7;
        if (data_width == 64) return 8;
        return 0;
    endfunction

    // Expand up to eight byte enables into a 64-bit bit mask.
    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] mask;
        mask = '0;
        for (int i = 0; i < 8; i++) begin
            mask[i*8 +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    // Hsiao column for data bit idx: odd-weight (>=3) patterns in ascending
    // order, so data columns never alias a check-bit unit vector.
    function automatic logic [7:0] hsiao_col(input int ecc_w, input int idx);
        logic [7:0] col;
        int         n;
        col = '0;
        n   = 0;
        for (int w = 3; w <= ecc_w; w += 2) begin
            for (int v = 0; v < (1 << ecc_w); v++) begin
                if ($countones(8'(v)) == w) begin
                    if (n == idx) col = 8'(v);
                    n++;
                end
            end
        end
        return col;
    endfunction

endpackage

// File: rtl/ecc_sram_codec.sv
// Hsiao SECDED encoder plus decoder/corrector for 39/32 and 72/64 codewords.
// Codeword layout: {check bits, data}.
module ecc_sram_codec
    import ecc_sram_pkg::*;
#(
    parameter int DataWidth = 32,
    localparam int EccWidth = ecc_width(DataWidth),
    localparam int CwWidth  = DataWidth + EccWidth
) (
    input  logic [DataWidth-1:0] enc_data,
    output logic [CwWidth-1:0]   enc_cw,
    input  logic [CwWidth-1:0]   dec_cw,
    output logic [DataWidth-1:0] dec_data,
    output logic                 single_err,
    output logic                 multi_err
);

    logic [EccWidth-1:0] col_tbl [DataWidth];
    logic [EccWidth-1:0] enc_par;
    logic [EccWidth-1:0] dec_par;
    logic [EccWidth-1:0] syndrome;

    if (DataWidth == 32) begin : gen_secded_39_32
        for (genvar i = 0; i < 32; i++) begin : gen_col
            assign col_tbl[i] = EccWidth'(hsiao_col(7, i));
        end
    end else if (DataWidth == 64) begin : gen_secded_72_64
        for (genvar i = 0; i < 64; i++) begin : gen_col
            assign col_tbl[i] = EccWidth'(hsiao_col(8, i));
        end
    end else begin : gen_bad_width
        $error("ecc_sram_codec: DataWidth must be 32 or 64");
    end

    // Check bits of the outgoing payload.
    always_comb begin
        enc_par = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (enc_data[i]) enc_par = enc_par ^ col_tbl[i];
        end
    end

    assign enc_cw = {enc_par, enc_data};

    // Recomputed check bits of the incoming payload.
    always_comb begin
        dec_par = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (dec_cw[i]) dec_par = dec_par ^ col_tbl[i];
        end
    end

    assign syndrome = dec_par ^ dec_cw[CwWidth-1:DataWidth];

    // Flip the single data bit whose column matches the syndrome.
    always_comb begin
        dec_data = dec_cw[DataWidth-1:0];
        for (int i = 0; i < DataWidth; i++) begin
            if (syndrome == col_tbl[i]) dec_data[i] = ~dec_cw[i];
        end
    end

    // Odd syndrome weight = one flipped bit; even nonzero = two flipped bits.
    assign single_err = ^syndrome;
    assign multi_err  = (syndrome != '0) && !(^syndrome);

endmodule

// File: rtl/ecc_sram_rmw_bank.sv
// SECDED-protected single-port bank with read-modify-write for sub-word
// stores and optional scrub of corrected single-bit read errors.
//
// state | meaning
// IDLE  | accepting requests; full stores write, loads/partial stores read
// RMW   | merge buffered partial store with corrected read data and write
// SCRUB | write re-encoded corrected load data back to addr_q
module ecc_sram_rmw_bank
    import ecc_sram_pkg::*;
#(
    parameter int NumWords           = 256,
    parameter int DataWidth          = 32,
    parameter bit WritebackCorrected = 1'b1,
    parameter int CntWidth           = 16,
    localparam int AddrWidth = $clog2(NumWords),
    localparam int BeWidth   = DataWidth / 8,
    localparam int EccWidth  = ecc_width(DataWidth),
    localparam int CwWidth   = DataWidth + EccWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 single_err_o,
    output logic                 multi_err_o,
    output logic [CntWidth-1:0]  err_cnt_o,
    input  logic                 err_cnt_clr_i
);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : gen_width_check
        $error("ecc_sram_rmw_bank: DataWidth must be 32 or 64");
    end

    state_e               state_q;
    logic [AddrWidth-1:0] addr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [BeWidth-1:0]   be_q;
    logic [CwWidth-1:0]   rd_cw_q;
    logic                 resp_q;
    logic                 resp_rd_q;
    logic                 resp_load_q;
    logic [CntWidth-1:0]  cnt_q;

    logic [CwWidth-1:0]   mem [NumWords];

    logic                 full_be;
    logic                 gnt;
    logic                 rd_en;
    logic                 scrub_enter;
    logic                 mem_we;
    logic [AddrWidth-1:0] mem_waddr;
    logic [DataWidth-1:0] mask;
    logic [DataWidth-1:0] merged;
    logic [DataWidth-1:0] enc_in;
    logic [CwWidth-1:0]   enc_cw;
    logic [DataWidth-1:0] dec_data;
    logic                 dec_single;
    logic                 dec_multi;

    ecc_sram_codec #(
        .DataWidth (DataWidth)
    ) u_codec (
        .enc_data   (enc_in),
        .enc_cw     (enc_cw),
        .dec_cw     (rd_cw_q),
        .dec_data   (dec_data),
        .single_err (dec_single),
        .multi_err  (dec_multi)
    );

    assign full_be     = &be_i;
    assign scrub_enter = WritebackCorrected && (state_q == IDLE) && resp_q
                         && resp_load_q && dec_single;
    // Reset gates the grant so nothing is written or acknowledged during reset.
    assign gnt         = rst_ni && req_i && (state_q == IDLE) && !scrub_enter;
    assign rd_en       = gnt && !(we_i && full_be);

    assign mask   = DataWidth'(be_to_mask(8'(be_q)));
    assign merged = (mask & wdata_q) | (~mask & dec_data);

    // Encoder source and write port control follow the FSM state.
    always_comb begin
        enc_in    = wdata_i;
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        case (state_q)
            IDLE: begin
                mem_we    = gnt && we_i && full_be;
                mem_waddr = addr_i;
            end
            RMW: begin
                enc_in = merged;
                mem_we = !dec_multi;
            end
            SCRUB: begin
                enc_in = dec_data;
                mem_we = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= enc_cw;
    end

    // FSM, request buffer, read port register and response tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rd_cw_q     <= '0;
            resp_q      <= 1'b0;
            resp_rd_q   <= 1'b0;
            resp_load_q <= 1'b0;
        end else begin
            resp_q      <= gnt;
            resp_rd_q   <= rd_en;
            resp_load_q <= gnt && !we_i;
            if (rd_en) begin
                rd_cw_q <= mem[addr_i];
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            case (state_q)
                IDLE: begin
                    if (gnt && we_i && !full_be) state_q <= RMW;
                    else if (scrub_enter)        state_q <= SCRUB;
                end
                RMW:     state_q <= IDLE;
                SCRUB:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Saturating corrected-error counter; clear has priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (err_cnt_clr_i) begin
            cnt_q <= '0;
        end else if (single_err_o && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign gnt_o        = gnt;
    assign rvalid_o     = resp_q;
    assign rdata_o      = resp_load_q ? dec_data : '0;
    assign single_err_o = resp_rd_q && dec_single;
    assign multi_err_o  = resp_rd_q && dec_multi;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_ecc_sram_rmw_bank.sv
// Directed bench for ecc_sram_rmw_bank (32-bit data, 4-bit error counter).
module tb_ecc_sram_rmw_bank;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        single_err_o;
    logic        multi_err_o;
    logic [3:0]  err_cnt_o;
    logic        err_cnt_clr_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    ecc_sram_rmw_bank #(
        .NumWords           (256),
        .DataWidth          (32),
        .WritebackCorrected (1'b1),
        .CntWidth           (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .we_i          (we_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .be_i          (be_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .single_err_o  (single_err_o),
        .multi_err_o   (multi_err_o),
        .err_cnt_o     (err_cnt_o),
        .err_cnt_clr_i (err_cnt_clr_i)
    );

    task automatic drive(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wd;
        be_i    = be;
    endtask

    // One request from posedge+1, held until granted; returns at posedge+1 after the response cycle.
    task automatic xact(input logic we, input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] be,
                        output int stalls, output logic rv, output logic [31:0] rd,
                        output logic se, output logic me);
        drive(we, addr, wd, be);
        stalls = 0;
        @(negedge clk_i);
        while (!gnt_o && stalls < 20) begin
            stalls++;
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        rv = rvalid_o;
        rd = rdata_o;
        se = single_err_o;
        me = multi_err_o;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #1 drive(1'b0, 8'd5, 32'h0, 4'hF);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
        checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        checks++; if ({single_err_o, multi_err_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {single_err_o, multi_err_o}); end
        checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", err_cnt_o); end
        req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_full_store_load();
        int st; logic rv, se, me; logic [31:0] rd;
        xact(1'b1, 8'd5, 32'hDEADBEEF, 4'hF, st, rv, rd, se, me);
        checks++; if (st !== 0) begin errors++; $display("FAIL store_stall: got %0d want 0", st); end
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL store_rvalid: got %b want 1", rv); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
        xact(1'b0, 8'd5, 32'h0, 4'h0, st, rv, rd, se, me);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL load5_rvalid: got %b want 1", rv); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load5_rdata: got %h want deadbeef", rd); end
        checks++; if ({se, me} !== 2'b00) begin errors++; $display("FAIL load5_flags: got %b want 00", {se, me}); end
    endtask

    task automatic test_partial_store();
        int st; logic rv, se, me; logic [31:0] rd;
        xact(1'b1, 8'd7, 32'h11223344, 4'hF, st, rv, rd, se, me);
        drive(1'b1, 8'd7, 32'h0000AB00, 4'b0010);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL pst_gnt: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 drive(1'b0, 8'd7, 32'h0, 4'h0);
        @(negedge clk_i);
        checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL rmw_rvalid: got %b want 1", rvalid_o); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL rmw_gnt: got %b want 0", gnt_o); end
        checks++; if ({single_err_o, multi_err_o} !== 2'b00) begin errors++; $display("FAIL rmw_flags: got %b want 00", {single_err_o, multi_err_o}); end
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL after_rmw_gnt: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (rdata_o !== 32'h1122AB44) begin errors++; $display("FAIL merge_rdata: got %h want 1122ab44", rdata_o); end
        @(posedge clk_i);
        #1;
        // Zero byte enables: still a partial store, memory content unchanged.
        xact(1'b1, 8'd7, 32'hFFFFFFFF, 4'h0, st, rv, rd, se, me);
        xact(1'b0, 8'd7, 32'h0, 4'h0, st, rv, rd, se, me);
        checks++; if (rd !== 32'h1122AB44) begin errors++; $display("FAIL be0_rdata: got %h want 1122ab44", rd); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 8'd20, 32'hA5A5A5A5, 4'hF);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 drive(1'b0, 8'd20, 32'h0, 4'h0);
        @(negedge clk_i);
        checks++; if ({gnt_o, rvalid_o} !== 2'b11) begin errors++; $display("FAIL b2b_c1: got gnt/rvalid %b want 11", {gnt_o, rvalid_o}); end
        @(posedge clk_i);
        #1 drive(1'b0, 8'd5, 32'h0, 4'h0);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt2: got %b want 1", gnt_o); end
        checks++; if (rdata_o !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_rd20: got %h want a5a5a5a5", rdata_o); end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rd5: got %h want deadbeef", rdata_o); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_scrub();
        int st; logic rv, se, me; logic [31:0] rd;
        xact(1'b1, 8'd9, 32'hCAFEF00D, 4'hF, st, rv, rd, se, me);
        dut.mem[9][4] = ~dut.mem[9][4];
        drive(1'b0, 8'd9, 32'h0, 4'h0);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL scrub_gnt0: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checks++; if (rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL sbe_rdata: got %h want cafef00d", rdata_o); end
        checks++; if ({rvalid_o, single_err_o, multi_err_o} !== 3'b110) begin errors++; $display("FAIL sbe_flags: got %b want 110", {rvalid_o, single_err_o, multi_err_o}); end
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL scrub_stall1: got %b want 0", gnt_o); end
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL scrub_stall2: got %b want 0", gnt_o); end
        checks++; if (err_cnt_o !== 4'd1) begin errors++; $display("FAIL scrub_cnt: got %0d want 1", err_cnt_o); end
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL scrub_regrant: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL reload_rdata: got %h want cafef00d", rdata_o); end
        checks++; if (single_err_o !== 1'b0) begin errors++; $display("FAIL reload_single: got %b want 0", single_err_o); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_multi();
        int st; logic rv, se, me; logic [31:0] rd;
        dut.mem[3] = 39'h3;
        xact(1'b1, 8'd3, 32'h000000FF, 4'b0001, st, rv, rd, se, me);
        checks++; if ({rv, se, me} !== 3'b101) begin errors++; $display("FAIL dbe_flags: got %b want 101", {rv, se, me}); end
        checks++; if (dut.mem[3] !== 39'h3) begin errors++; $display("FAIL dbe_mem: got %h want 3", dut.mem[3]); end
        checks++; if (err_cnt_o !== 4'd1) begin errors++; $display("FAIL dbe_cnt: got %0d want 1", err_cnt_o); end
        xact(1'b0, 8'd3, 32'h0, 4'h0, st, rv, rd, se, me);
        checks++; if ({se, me} !== 2'b01) begin errors++; $display("FAIL dbe_load: got %b want 01", {se, me}); end
    endtask

    task automatic test_counter_sat();
        int st; logic rv, se, me; logic [31:0] rd;
        int exp_cnt;
        err_cnt_clr_i = 1'b1;
        @(posedge clk_i);
        #1 err_cnt_clr_i = 1'b0;
        checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", err_cnt_o); end
        for (int k = 1; k <= 18; k++) begin
            dut.mem[9][(k * 5) % 39] = ~dut.mem[9][(k * 5) % 39];
            xact(1'b0, 8'd9, 32'h0, 4'h0, st, rv, rd, se, me);
            exp_cnt = (k > 15) ? 15 : k;
            checks++; if ({se, rd} !== {1'b1, 32'hCAFEF00D}) begin errors++; $display("FAIL sat_load%0d: got se=%b rd=%h want se=1 rd=cafef00d", k, se, rd); end
            checks++; if (err_cnt_o !== exp_cnt[3:0]) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, err_cnt_o, exp_cnt); end
            @(posedge clk_i);
            #1;
        end
        dut.mem[9][0] = ~dut.mem[9][0];
        drive(1'b0, 8'd9, 32'h0, 4'h0);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL clrinc_gnt: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        err_cnt_clr_i = 1'b1;
        @(negedge clk_i);
        checks++; if (single_err_o !== 1'b1) begin errors++; $display("FAIL clrinc_single: got %b want 1", single_err_o); end
        @(posedge clk_i);
        #1 err_cnt_clr_i = 1'b0;
        checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL clrinc_cnt: got %0d want 0", err_cnt_o); end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_mid_rmw();
        int st; logic rv, se, me; logic [31:0] rd;
        drive(1'b1, 8'd7, 32'h55000000, 4'b1000);
        @(negedge clk_i);
        checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rstrmw_gnt: got %b want 1", gnt_o); end
        @(posedge clk_i);
        #1 req_i = 1'b0;
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        checks++; if ({rvalid_o, single_err_o, multi_err_o} !== 3'b000) begin errors++; $display("FAIL rstrmw_outs: got %b want 000", {rvalid_o, single_err_o, multi_err_o}); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rstrmw_rdata: got %h want 0", rdata_o); end
        checks++; if (err_cnt_o !== 4'd0) begin errors++; $display("FAIL rstrmw_cnt: got %0d want 0", err_cnt_o); end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        xact(1'b0, 8'd7, 32'h0, 4'h0, st, rv, rd, se, me);
        checks++; if (st !== 0) begin errors++; $display("FAIL rstrmw_first_gnt: stalled %0d cycles want 0", st); end
        checks++; if (rd !== 32'h1122AB44) begin errors++; $display("FAIL rstrmw_word: got %h want 1122ab44", rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni        = 1'b0;
        req_i         = 1'b0;
        we_i          = 1'b0;
        addr_i        = '0;
        wdata_i       = '0;
        be_i          = '0;
        err_cnt_clr_i = 1'b0;
        for (int i = 0; i < 256; i++) dut.mem[i] = '0;
        test_reset();
        test_full_store_load();
        test_partial_store();
        test_back_to_back();
        test_scrub();
        test_multi();
        test_counter_sat();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
